// File: rtl/hwpe_stream_package.sv
// Shared types and the next-non-zero-beat search used by the stride serializer.
package hwpe_stream_package;

   localparam int unsigned MAX_BEATS = 64;
   localparam int unsigned IDX_W     = $clog2(MAX_BEATS);

   typedef enum logic [0:0] {StIdle, StSerial} serialize_state_e;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } beat_search_t;

   // Lowest beat index >= from whose non-zero flag is set.
   function automatic beat_search_t next_nz_beat(input logic [MAX_BEATS-1:0] nz,
                                                 input int unsigned from);
      beat_search_t res;
      res = '0;
      for (int unsigned i = 0; i < MAX_BEATS; i++) begin
         if (!res.found && nz[i] && (i >= from)) begin
            res.found = 1'b1;
            res.idx   = IDX_W'(i);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream with per-byte strobes.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                    valid;
   logic                    ready;
   logic [DATA_WIDTH-1:0]   data;
   logic [DATA_WIDTH/8-1:0] strb;

   modport source (output valid, data, strb, input ready);
   modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/hwpe_stream_serialize_stride.sv
// Serializes a wide strided stream into DATA_WIDTH_OUT beats, LSB slice first.
// Define HWPE_STREAM_SERIALIZE_SKIP_ZERO_STRB_EN to suppress beats whose strobe slice is all-zero.
module hwpe_stream_serialize_stride
   import hwpe_stream_package::*;
#(
   parameter int unsigned DATA_WIDTH_IN  = 256,
   parameter int unsigned DATA_WIDTH_OUT = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   hwpe_stream_intf_stream.sink   push_i,
   hwpe_stream_intf_stream.source pop_o,
   output logic                  last_o
);

   localparam int unsigned NB_BEATS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
   localparam int unsigned STRB_IN  = DATA_WIDTH_IN / 8;
   localparam int unsigned STRB_OUT = DATA_WIDTH_OUT / 8;
   localparam int unsigned CNT_W    = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;

   if (NB_BEATS < 2 || (NB_BEATS & (NB_BEATS - 1)) != 0) begin : g_err_beats
      $error("NB_BEATS must be a power of two >= 2");
   end
   if ((DATA_WIDTH_OUT % 8) != 0 || (DATA_WIDTH_IN % DATA_WIDTH_OUT) != 0) begin : g_err_width
      $error("DATA_WIDTH_OUT must be a multiple of 8 dividing DATA_WIDTH_IN");
   end

   serialize_state_e     state_q, state_d;
   logic [DATA_WIDTH_IN-1:0] data_q, data_d;
   logic [STRB_IN-1:0]   strb_q, strb_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic             busy;
   logic             last;
   logic             push_hs;
   logic             pop_hs;
   logic             load_ok;
   logic [CNT_W-1:0] first_idx;
   logic [CNT_W-1:0] next_idx;

   assign busy = (state_q == StSerial);

`ifdef HWPE_STREAM_SERIALIZE_SKIP_ZERO_STRB_EN
   if (NB_BEATS > MAX_BEATS) begin : g_err_max
      $error("NB_BEATS exceeds the beat search range");
   end

   logic [MAX_BEATS-1:0] nz_in;
   logic [MAX_BEATS-1:0] nz_reg;
   beat_search_t         first_res;
   beat_search_t         next_res;

   always_comb begin
      nz_in  = '0;
      nz_reg = '0;
      for (int unsigned b = 0; b < NB_BEATS; b++) begin
         nz_in[b]  = |push_i.strb[b*STRB_OUT +: STRB_OUT];
         nz_reg[b] = |strb_q[b*STRB_OUT +: STRB_OUT];
      end
      first_res = next_nz_beat(nz_in, 32'd0);
      next_res  = next_nz_beat(nz_reg, 32'(cnt_q) + 32'd1);
   end

   // An all-zero word is still handshaked but never enters SERIAL.
   assign load_ok   = first_res.found;
   assign first_idx = CNT_W'(first_res.idx);
   assign next_idx  = CNT_W'(next_res.idx);
   assign last      = busy & ~next_res.found;
`else
   assign load_ok   = 1'b1;
   assign first_idx = '0;
   assign next_idx  = cnt_q + CNT_W'(1);
   assign last      = busy & (cnt_q == CNT_W'(NB_BEATS - 1));
`endif

   // Ready depends only on registered state and pop_o.ready.
   assign push_i.ready = ~busy | (pop_o.ready & last);
   assign pop_o.valid  = busy;
   assign pop_o.data   = data_q[cnt_q*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
   assign pop_o.strb   = strb_q[cnt_q*STRB_OUT +: STRB_OUT];
   assign last_o       = last;

   assign push_hs = push_i.valid & push_i.ready;
   assign pop_hs  = pop_o.valid & pop_o.ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      strb_d  = strb_q;
      if (pop_hs) begin
         if (last) begin
            state_d = StIdle;
         end else begin
            cnt_d = next_idx;
         end
      end
      // A push coinciding with the last pop reloads without a bubble.
      if (push_hs) begin
         data_d  = push_i.data;
         strb_d  = push_i.strb;
         cnt_d   = first_idx;
         state_d = load_ok ? StSerial : StIdle;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         data_q  <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
      end
   end

endmodule

// File: tb/tb_hwpe_stream_serialize_stride.sv
// Self-checking bench for hwpe_stream_serialize_stride: directed cases plus random traffic vs a
// beat-queue reference model (skip-zero cases when HWPE_STREAM_SERIALIZE_SKIP_ZERO_STRB_EN is set).
module tb_hwpe_stream_serialize_stride;

   localparam int unsigned WI = 256;
   localparam int unsigned WO = 64;
   localparam int unsigned NB = WI / WO;
   localparam int unsigned SO = WO / 8;
   localparam int unsigned NWORDS = 2000;

   typedef struct {
      logic [WO-1:0] d;
      logic [SO-1:0] s;
      logic          l;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic push_valid = 1'b0;
   logic [WI-1:0] push_data = '0;
   logic [WI/8-1:0] push_strb = '0;
   logic pop_ready = 1'b0;
   logic last;

   hwpe_stream_intf_stream #(.DATA_WIDTH(WI)) push_if ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(WO)) pop_if ();

   assign push_if.valid = push_valid;
   assign push_if.data  = push_data;
   assign push_if.strb  = push_strb;
   assign pop_if.ready  = pop_ready;

   hwpe_stream_serialize_stride #(
      .DATA_WIDTH_IN (WI),
      .DATA_WIDTH_OUT(WO)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .push_i(push_if),
      .pop_o (pop_if),
      .last_o(last)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cycle = 0;
   beat_t exp_q[$];
   int push_cyc_q[$];
   int pop_cyc_q[$];
   logic push_acc;
   logic held_vld = 1'b0;
   logic [WO-1:0] held_d;
   logic [SO-1:0] held_s;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
      end
   endtask

   // Reference: a word becomes its LSB-first slices, optionally minus all-zero-strobe slices.
   task automatic model_push(input logic [WI-1:0] d, input logic [WI/8-1:0] s);
      beat_t tmp[$];
      beat_t b;
      for (int i = 0; i < int'(NB); i++) begin
         b.d = d[i*WO +: WO];
         b.s = s[i*SO +: SO];
         b.l = 1'b0;
`ifdef HWPE_STREAM_SERIALIZE_SKIP_ZERO_STRB_EN
         if (b.s != '0) tmp.push_back(b);
`else
         tmp.push_back(b);
`endif
      end
      if (tmp.size() > 0) tmp[tmp.size()-1].l = 1'b1;
      foreach (tmp[i]) exp_q.push_back(tmp[i]);
   endtask

   task automatic sample();
      beat_t e;
      push_acc = 1'b0;
      if (rst) begin
         held_vld = 1'b0;
      end else begin
         if (held_vld) begin
            check("stall_valid", 64'(pop_if.valid), 64'd1);
            check("stall_data", pop_if.data, held_d);
            check("stall_strb", 64'(pop_if.strb), 64'(held_s));
         end
         held_vld = pop_if.valid && !pop_ready;
         held_d   = pop_if.data;
         held_s   = pop_if.strb;
         if (!pop_if.valid) check("idle_last", 64'(last), 64'd0);
         if (pop_if.valid && pop_ready) begin
            pop_cyc_q.push_back(cycle);
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(pop_if.valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", pop_if.data, e.d);
               check("beat_strb", 64'(pop_if.strb), 64'(e.s));
               check("beat_last", 64'(last), 64'(e.l));
            end
         end
         if (push_valid && push_if.ready) begin
            push_acc = 1'b1;
            push_cyc_q.push_back(cycle);
            model_push(push_data, push_strb);
         end
      end
      cycle++;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WI-1:0] rand_word();
      logic [WI-1:0] w;
      for (int i = 0; i < int'(WI / 32); i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [WI/8-1:0] rand_strb();
      logic [WI/8-1:0] s;
      int r;
      for (int i = 0; i < int'(NB); i++) begin
         r = $urandom_range(0, 3);
         s[i*SO +: SO] = (r == 0) ? '0 : (r == 1) ? '1 : SO'($urandom);
      end
      return s;
   endfunction

   initial begin
      logic [WI-1:0] w;
      int base;
      int nacc;
      int budget;

      // Reset state
      tick();
      tick();
      check("rst_valid", 64'(pop_if.valid), 64'd0);
      check("rst_last", 64'(last), 64'd0);
      check("rst_ready", 64'(push_if.ready), 64'd1);
      rst = 1'b0;

      // Single word, beats 0..3 on cycles 1..4
      for (int i = 0; i < int'(NB); i++) w[i*WO +: WO] = 64'(i);
      push_data = w;
      push_strb = '1;
      push_valid = 1'b1;
      pop_ready = 1'b1;
      tick();
      check("single_accept", 64'(push_acc), 64'd1);
      push_valid = 1'b0;
      for (int i = 1; i <= int'(NB); i++) begin
         check("single_valid", 64'(pop_if.valid), 64'd1);
         check("single_data", pop_if.data, 64'(i - 1));
         check("single_last", 64'(last), 64'(i == int'(NB)));
         check("single_ready", 64'(push_if.ready), 64'(i == int'(NB)));
         tick();
      end
      check("single_done", 64'(pop_if.valid), 64'd0);

      // Back-to-back: three words, no bubble
      push_cyc_q.delete();
      pop_cyc_q.delete();
      base = cycle;
      nacc = 0;
      push_data = rand_word();
      push_strb = '1;
      push_valid = 1'b1;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (push_acc) begin
            nacc++;
            push_data = rand_word();
            if (nacc == 3) push_valid = 1'b0;
         end
      end
      check("b2b_pushes", 64'(push_cyc_q.size()), 64'd3);
      for (int k = 0; k < push_cyc_q.size(); k++)
         check("b2b_push_cycle", 64'(push_cyc_q[k] - base), 64'(4 * k));
      check("b2b_beats", 64'(pop_cyc_q.size()), 64'(3 * NB));
      if (pop_cyc_q.size() > 0)
         check("b2b_span", 64'(pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[0]), 64'(3 * NB - 1));

      // Backpressure: pop_ready pattern 1,0,0,1
      push_data = rand_word();
      push_strb = rand_strb();
      push_valid = 1'b1;
      nacc = 0;
      for (int c = 0; c < 48; c++) begin
         pop_ready = (c % 4 == 0) || (c % 4 == 3);
         tick();
         if (push_acc) begin
            nacc++;
            push_data = rand_word();
            push_strb = rand_strb();
            if (nacc == 2) push_valid = 1'b0;
         end
      end
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Reset mid-word after beat 1
      pop_ready = 1'b1;
      push_data = rand_word();
      push_strb = '1;
      push_valid = 1'b1;
      tick();
      push_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      pop_ready = 1'b0;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check("midrst_valid", 64'(pop_if.valid), 64'd0);
      check("midrst_ready", 64'(push_if.ready), 64'd1);
      check("midrst_last", 64'(last), 64'd0);
      w = rand_word();
      push_data = w;
      push_valid = 1'b1;
      pop_ready = 1'b1;
      tick();
      push_valid = 1'b0;
      check("midrst_restart", pop_if.data, w[WO-1:0]);
      for (int c = 0; c < int'(NB); c++) tick();

`ifdef HWPE_STREAM_SERIALIZE_SKIP_ZERO_STRB_EN
      // Skip: only beats 1 and 3 carry strobes
      pop_cyc_q.delete();
      push_data = rand_word();
      push_strb = 32'h0F00_FF00;
      push_valid = 1'b1;
      tick();
      push_valid = 1'b0;
      for (int c = 0; c < 6; c++) tick();
      check("skip_beats", 64'(pop_cyc_q.size()), 64'd2);
      // All-zero strobe word is accepted and dropped
      push_data = rand_word();
      push_strb = '0;
      push_valid = 1'b1;
      tick();
      check("zero_accept", 64'(push_acc), 64'd1);
      push_valid = 1'b0;
      check("zero_valid", 64'(pop_if.valid), 64'd0);
      check("zero_ready", 64'(push_if.ready), 64'd1);
      tick();
      check("zero_valid2", 64'(pop_if.valid), 64'd0);
`endif

      // Random valid/ready traffic
      nacc = 0;
      budget = 0;
      push_data = rand_word();
      push_strb = rand_strb();
      push_valid = 1'($urandom_range(0, 1));
      while (nacc < int'(NWORDS) && budget < 60000) begin
         pop_ready = 1'($urandom_range(0, 1));
         tick();
         budget++;
         if (push_acc) begin
            nacc++;
            push_data = rand_word();
            push_strb = rand_strb();
            push_valid = 1'($urandom_range(0, 1));
         end else if (!push_valid) begin
            push_valid = 1'($urandom_range(0, 1));
         end
      end
      check("rand_words", 64'(nacc), 64'(NWORDS));
      push_valid = 1'b0;
      pop_ready = 1'b1;
      for (int c = 0; c < 16; c++) tick();
      check("rand_drained", 64'(exp_q.size()), 64'd0);
      check("rand_idle", 64'(pop_if.valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
